// File: rtl/shift_engine_pkg.sv
// Shared constants and types for the multi-cycle shift engine.
// Fill-mode encodings and the sequencer state enum.
package shift_engine_pkg;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;
    localparam logic [1:0] MODE_RTC = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step.
// dir: 0 = left, 1 = right; the displaced bit becomes the new carry.
module shift_step
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             carry,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_data,
    output logic             next_carry
);

    logic fill;

    always_comb begin
        fill = 1'b0;
        if (!dir) begin
            unique case (mode)
                MODE_LOG, MODE_ARI: fill = 1'b0;
                MODE_ROT:           fill = data[WIDTH-1];
                MODE_RTC:           fill = carry;
            endcase
            next_data  = {data[WIDTH-2:0], fill};
            next_carry = data[WIDTH-1];
        end else begin
            unique case (mode)
                MODE_LOG: fill = 1'b0;
                MODE_ARI: fill = data[WIDTH-1];
                MODE_ROT: fill = data[0];
                MODE_RTC: fill = carry;
            endcase
            next_data  = {fill, data[WIDTH-1:1]};
            next_carry = data[0];
        end
    end

endmodule

// File: rtl/shift_engine.sv
// Multi-cycle shifter: one bit per cycle, with a one-cycle done pulse.
// Operands are latched on accept so input changes cannot disturb a run.
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [AW-1:0]    AMT,
    input  logic             LR,
    input  logic [1:0]       MODE,
    input  logic             CIN,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             busy,
    output logic             done
);

    state_t            state;
    state_t            state_n;
    logic [AW-1:0]     count;
    logic [AW-1:0]     count_n;
    logic              lr_q;
    logic              lr_n;
    logic [1:0]        mode_q;
    logic [1:0]        mode_n;
    logic [WIDTH-1:0]  y_n;
    logic              c_n;
    logic [WIDTH-1:0]  step_y;
    logic              step_c;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data       (Y),
        .carry      (C),
        .dir        (lr_q),
        .mode       (mode_q),
        .next_data  (step_y),
        .next_carry (step_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            Y      <= '0;
            C      <= 1'b0;
            count  <= '0;
            lr_q   <= 1'b0;
            mode_q <= MODE_LOG;
        end else begin
            state  <= state_n;
            Y      <= y_n;
            C      <= c_n;
            count  <= count_n;
            lr_q   <= lr_n;
            mode_q <= mode_n;
        end
    end

    always_comb begin
        state_n = state;
        y_n     = Y;
        c_n     = C;
        count_n = count;
        lr_n    = lr_q;
        mode_n  = mode_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    y_n     = A;
                    c_n     = CIN;
                    count_n = AMT;
                    lr_n    = LR;
                    mode_n  = MODE;
                    state_n = (AMT == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                y_n     = step_y;
                c_n     = step_c;
                count_n = count - AW'(1);
                if (count == AW'(1)) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench: directed literal cases plus randomized traffic
// compared every cycle against a whole-operation arithmetic model.
module tb_shift_engine;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [2:0]   AMT;
    logic         LR;
    logic [1:0]   MODE;
    logic         CIN;
    logic [W-1:0] Y;
    logic         C;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;
    int m_rem = -1;
    logic [W-1:0] m_y = '0;
    logic         m_c = 1'b0;
    logic         check_en = 1'b0;

    shift_engine #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .AMT   (AMT),
        .LR    (LR),
        .MODE  (MODE),
        .CIN   (CIN),
        .Y     (Y),
        .C     (C),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Whole-operation result from plain shift/rotate arithmetic.
    function automatic void ref_op(input logic [W-1:0] a, input logic [2:0] amt,
                                   input logic lr, input logic [1:0] mode,
                                   input logic cin, output logic [W-1:0] y,
                                   output logic c);
        logic [W:0] v;
        int n;
        n = int'(amt);
        y = a;
        c = cin;
        if (mode == 2'b11) begin
            v = {cin, a};
            if (!lr) v = (v << n) | (v >> (W + 1 - n));
            else     v = (v >> n) | (v << (W + 1 - n));
            y = v[W-1:0];
            c = v[W];
        end else if (mode == 2'b10) begin
            if (n != 0) begin
                if (!lr) begin
                    y = (a << n) | (a >> (W - n));
                    c = y[0];
                end else begin
                    y = (a >> n) | (a << (W - n));
                    c = y[W-1];
                end
            end
        end else if (!lr) begin
            v = {cin, a} << n;
            y = v[W-1:0];
            c = v[W];
        end else if (mode == 2'b00) begin
            v = {a, cin} >> n;
            y = v[W:1];
            c = v[0];
        end else begin
            v = $signed({a, cin}) >>> n;
            y = v[W:1];
            c = v[0];
        end
    endfunction

    // Model state: m_rem = cycles left until done is visible, -1 when idle.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem = -1;
            m_y   = '0;
            m_c   = 1'b0;
        end else if (m_rem < 0) begin
            if (start) begin
                ref_op(A, AMT, LR, MODE, CIN, m_y, m_c);
                m_rem = int'(AMT);
            end
        end else begin
            m_rem = m_rem - 1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("busy", 32'(busy), 32'(m_rem >= 0));
            check("done", 32'(done), 32'(m_rem == 0));
            if (m_rem <= 0) begin
                check("Y", 32'(Y), 32'(m_y));
                check("C", 32'(C), 32'(m_c));
            end
        end
    end

    task automatic pin_model(input logic [W-1:0] a, input logic [2:0] amt,
                             input logic lr, input logic [1:0] mode,
                             input logic cin, input logic [W-1:0] ey,
                             input logic ec);
        logic [W-1:0] y;
        logic c;
        ref_op(a, amt, lr, mode, cin, y, c);
        check("model_y", 32'(y), 32'(ey));
        check("model_c", 32'(c), 32'(ec));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [2:0] amt,
                          input logic lr, input logic [1:0] mode,
                          input logic cin, input logic [W-1:0] ey,
                          input logic ec, input int elat, input bit poke);
        int lat;
        int guard;
        guard = 0;
        while (m_rem >= 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        A     = a;
        AMT   = amt;
        LR    = lr;
        MODE  = mode;
        CIN   = cin;
        start = 1'b1;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            A     = 8'($urandom);
            AMT   = 3'($urandom);
            LR    = 1'($urandom);
            MODE  = 2'($urandom);
            CIN   = 1'($urandom);
            if (poke && lat == 2) start = 1'b1;
        end while (!done && lat < 40);
        start = 1'b0;
        check("latency", 32'(lat), 32'(elat));
        check("result_y", 32'(Y), 32'(ey));
        check("result_c", 32'(C), 32'(ec));
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        AMT   = '0;
        LR    = 1'b0;
        MODE  = 2'b00;
        CIN   = 1'b0;

        pin_model(8'h81, 3'd1, 1'b0, 2'b00, 1'b0, 8'h02, 1'b1);
        pin_model(8'h80, 3'd3, 1'b1, 2'b01, 1'b0, 8'hF0, 1'b0);
        pin_model(8'h01, 3'd2, 1'b1, 2'b11, 1'b0, 8'h80, 1'b0);
        pin_model(8'h96, 3'd4, 1'b0, 2'b10, 1'b0, 8'h69, 1'b1);
        pin_model(8'h5A, 3'd0, 1'b1, 2'b11, 1'b1, 8'h5A, 1'b1);

        @(negedge clk);
        @(negedge clk);
        check("rst_y", 32'(Y), 32'h0);
        check("rst_c", 32'(C), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h81, 3'd1, 1'b0, 2'b00, 1'b0, 8'h02, 1'b1, 2, 1'b0);
        run_op(8'h80, 3'd3, 1'b1, 2'b01, 1'b1, 8'hF0, 1'b0, 4, 1'b0);
        run_op(8'h01, 3'd2, 1'b1, 2'b11, 1'b0, 8'h80, 1'b0, 3, 1'b0);
        run_op(8'h96, 3'd4, 1'b0, 2'b10, 1'b0, 8'h69, 1'b1, 5, 1'b0);
        for (int m = 0; m < 4; m++) begin
            run_op(8'h5A, 3'd0, 1'(m), 2'(m), 1'b1, 8'h5A, 1'b1, 1, 1'b0);
        end
        run_op(8'h96, 3'd4, 1'b0, 2'b10, 1'b0, 8'h69, 1'b1, 5, 1'b1);
        run_op(8'hFF, 3'd7, 1'b0, 2'b00, 1'b0, 8'h80, 1'b1, 8, 1'b0);

        @(negedge clk);
        A     = 8'hFF;
        AMT   = 3'd6;
        LR    = 1'b0;
        MODE  = 2'b00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_y", 32'(Y), 32'h0);
        check("abort_c", 32'(C), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'h0);

        repeat (600) begin
            @(negedge clk);
            start = ($urandom_range(2) == 0);
            A     = 8'($urandom);
            AMT   = 3'($urandom);
            LR    = 1'($urandom);
            MODE  = 2'($urandom);
            CIN   = 1'($urandom);
            rst_n = ($urandom_range(59) != 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 Parameter WIDTH, default 8, operand width; SHALL be >= 2.
REQ-002 Parameter AW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 start  input  1  request; accepted only in IDLE.
REQ-006 A  input  WIDTH  operand, sampled on accept.
REQ-007 AMT  input  AW  shift count, sampled on accept.
REQ-008 LR  input  1  direction: 0 = left, 1 = right; sampled on accept.
REQ-009 MODE  input  2  fill mode: 00 logical, 01 arithmetic, 10 rotate, 11 rotate-through-carry; sampled on accept.
REQ-010 CIN  input  1  initial carry, sampled on accept.
REQ-011 Y  output  WIDTH  result register.
REQ-012 C  output  1  carry register; holds the last bit shifted out.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse; Y and C are final in that cycle.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-016 IDLE with start=1 SHALL load Y<=A, C<=CIN, count<=AMT, and latch LR and MODE.
- Goes to SHIFT if AMT != 0.
- Goes to DONE if AMT == 0.
REQ-017 SHIFT SHALL perform one 1-bit step per cycle and decrement count, going to DONE on the step where count reaches 0.
REQ-018 Left step: Y <= {Y[WIDTH-2:0], fill}, C <= Y[WIDTH-1].
- fill = 0 for modes 00 and 01 (arithmetic left equals logical left).
- fill = Y[WIDTH-1] for mode 10.
- fill = C for mode 11.
REQ-019 Right step: Y <= {fill, Y[WIDTH-1:1]}, C <= Y[0].
- fill = 0 for mode 00.
- fill = Y[WIDTH-1] for mode 01.
- fill = Y[0] for mode 10.
- fill = C for mode 11.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 Latency from the accept edge to done SHALL be AMT+1 cycles: minimum 1, maximum 2^AW.
REQ-022 AMT == 0 SHALL yield Y = A and C = CIN in all modes.
REQ-023 start while busy (SHIFT or DONE) SHALL be ignored, with no effect on state or latched operands.
REQ-024 Y and C SHALL hold their values from done until the next accepted start.
REQ-025 A, AMT, LR, MODE and CIN changing after accept SHALL NOT affect the operation in progress.

Reset
REQ-026 rst_n = 0 at a clock edge SHALL force IDLE, Y = 0, C = 0, busy = 0, done = 0 and count = 0.
REQ-027 Reset during SHIFT or DONE SHALL abort the operation with no done pulse.
REQ-028 start is not accepted in any cycle where rst_n = 0.

Structure
REQ-029 Package shift_engine_pkg SHALL hold:
- the MODE encoding constants (MODE_LOG, MODE_ARI, MODE_ROT, MODE_RTC);
- the FSM state enum.
REQ-030 One combinational sub-module, shift_step, SHALL implement a single 1-bit step.
- Inputs: data, carry, dir, mode.
- Outputs: next data, next carry.
REQ-031 The engine SHALL instantiate shift_step exactly once.

Verification
REQ-032 A=0x81, LR=0, MODE=00, AMT=1 -> done 2 cycles after accept; Y=0x02, C=1.
REQ-033 A=0x80, LR=1, MODE=01, AMT=3 -> done after 4 cycles; Y=0xF0, C=0.
REQ-034 A=0x01, LR=1, MODE=11, CIN=0, AMT=2 -> Y=0x80, C=0.
REQ-035 A=0x96, LR=0, MODE=10, AMT=4 -> Y=0x69, C=1.
REQ-036 A=0x5A, AMT=0, CIN=1, any mode -> done 1 cycle after accept; Y=0x5A, C=1.
REQ-037 Busy handling and reset abort:
- A second start mid-SHIFT -> ignored; the first result is unchanged.
- rst_n=0 mid-SHIFT -> next cycle Y=0, C=0, busy=0, and no done pulse.
